// File: rtl/uart_image_transmitter.sv
// Streams the image RAM out as UART 8N1 bytes in raster order.
// Define IMAGE_TX_HEADER_EN to prefix the frame with a 4-byte size header.
module uart_image_transmitter #(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int ADDR_WIDTH   =
    (IMAGE_WIDTH * IMAGE_HEIGHT > 1) ?
    $clog2(IMAGE_WIDTH * IMAGE_HEIGHT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam logic [CW-1:0] BAUD_LAST =
    CW'(DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST =
    ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    STOP,
    FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]         baud_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  baud_last;
  logic                  hdr_on;
  logic                  hdr_last;

`ifdef IMAGE_TX_HEADER_EN
  localparam state_t FIRST = START;
  localparam logic [15:0] W16 = 16'(IMAGE_WIDTH);
  localparam logic [15:0] H16 = 16'(IMAGE_HEIGHT);

  logic [1:0] hdr_cnt;
  logic       hdr_q;

  function automatic logic [7:0] hdr_byte(
    input logic [1:0] i
  );
    logic [7:0] b;
    unique case (i)
      2'd0:    b = W16[7:0];
      2'd1:    b = W16[15:8];
      2'd2:    b = H16[7:0];
      default: b = H16[15:8];
    endcase
    return b;
  endfunction

  assign hdr_on   = hdr_q;
  assign hdr_last = (hdr_cnt == 2'd3);
`else
  localparam state_t FIRST = FETCH;

  assign hdr_on   = 1'b0;
  assign hdr_last = 1'b0;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = FIRST;
      FETCH: state_n = WAIT;
      WAIT:  state_n = START;
      START: if (baud_last) state_n = DATA;
      DATA: begin
        if (baud_last && bit_cnt == 3'd7)
          state_n = STOP;
      end
      STOP: begin
        if (baud_last) begin
          if (hdr_on)
            state_n = hdr_last ? FETCH : START;
          else if (idx == IDX_LAST)
            state_n = FIN;
          else
            state_n = FETCH;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      START:   tx   = 1'b0;
      DATA:    tx   = shift_reg[bit_cnt];
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_addr = idx;

  // Counters restart on every state change, so each bit slot is DIV long.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      idx       <= '0;
`ifdef IMAGE_TX_HEADER_EN
      hdr_q     <= 1'b0;
      hdr_cnt   <= '0;
`endif
    end else begin
      if (state_n != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == START ||
                   state == DATA  ||
                   state == STOP) begin
        baud_cnt <= baud_last ? '0 :
                    baud_cnt + 1'b1;
        if (state == DATA && baud_last)
          bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == WAIT)
        shift_reg <= ram_data;

      if (state == STOP && state_n == FETCH &&
          !hdr_on)
        idx <= idx + 1'b1;

      if (state == FIN)
        idx <= '0;

`ifdef IMAGE_TX_HEADER_EN
      // Header bytes skip the RAM and load straight into the shifter.
      if (state == IDLE && start) begin
        hdr_q     <= 1'b1;
        hdr_cnt   <= '0;
        shift_reg <= hdr_byte(2'd0);
      end else if (state == STOP && baud_last &&
                   hdr_q) begin
        if (hdr_last) begin
          hdr_q <= 1'b0;
        end else begin
          hdr_cnt   <= hdr_cnt + 1'b1;
          shift_reg <= hdr_byte(hdr_cnt + 1'b1);
        end
      end
`endif
    end
  end

endmodule
